// File: rtl/matrix_add_arbiter.sv
// rtl/matrix_add_arbiter.sv - round-robin arbiter and sequencer sharing one 4x4 matrix_addition engine
module matrix_add_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int START_CYCLES   = 2,
  parameter int SETTLE_CYCLES  = 6,
  parameter int ENG_RST_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*128-1:0] req_a,
  input  logic [NUM_REQ*128-1:0] req_b,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [255:0]           rsp_data,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   eng_start,
  output logic [127:0]           eng_a,
  output logic [127:0]           eng_b,
  input  logic [255:0]           eng_c,
  input  logic                   eng_done,
  output logic                   eng_rst_n
);

  localparam int GW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int M0   = (START_CYCLES > SETTLE_CYCLES) ? START_CYCLES : SETTLE_CYCLES;
  localparam int M1   = (M0 > ENG_RST_CYCLES) ? M0 : ENG_RST_CYCLES;
  localparam int M2   = (M1 > TIMEOUT_CYCLES) ? M1 : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(M2 + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_SETTLE,
    S_CLEAR,
    S_RESP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   gnt_q, gnt_d;
  logic [GW-1:0]   last_q, last_d;
  logic [127:0]    eng_a_q, eng_a_d;
  logic [127:0]    eng_b_q, eng_b_d;
  logic [255:0]    res_q, res_d;
  logic            err_q, err_d;

  logic            any_req;
  logic [GW-1:0]   pick;

  // Round-robin pick: first valid requester above last_grant, wrapping.
  always_comb begin
    int idx;
    idx     = 0;
    any_req = 1'b0;
    pick    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!any_req && req_valid[idx]) begin
        any_req = 1'b1;
        pick    = GW'(idx);
      end
    end
  end

  // Sequencer next state: grant, start pulse, wait/timeout, settle, engine reset, response.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    eng_a_d = eng_a_q;
    eng_b_d = eng_b_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          gnt_d   = pick;
          eng_a_d = req_a[int'(pick)*128 +: 128];
          eng_b_d = req_b[int'(pick)*128 +: 128];
          cnt_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cnt_q == CW'(START_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (eng_done) begin
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES)) begin
          res_d   = '0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_CLEAR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SETTLE: begin
        if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          res_d   = eng_c;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_CLEAR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CLEAR: begin
        if (cnt_q == CW'(ENG_RST_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready[gnt_q]) begin
          last_d  = gnt_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      last_q  <= GW'(NUM_REQ - 1);
      eng_a_q <= '0;
      eng_b_q <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      eng_a_q <= eng_a_d;
      eng_b_q <= eng_b_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE && any_req && rst_n) ? (NUM_REQ'(1) << pick) : '0;
  assign rsp_valid = (state_q == S_RESP) ? (NUM_REQ'(1) << gnt_q) : '0;
  assign rsp_data  = res_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != S_IDLE);
  assign eng_start = (state_q == S_ISSUE);
  assign eng_a     = eng_a_q;
  assign eng_b     = eng_b_q;
  assign eng_rst_n = rst_n & (state_q != S_CLEAR);

endmodule

// File: tb/tb_matrix_add_arbiter.sv
// tb/tb_matrix_add_arbiter.sv - directed self-checking bench for matrix_add_arbiter
module tb_matrix_add_arbiter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [511:0] req_a = '0;
  logic [511:0] req_b = '0;
  logic [3:0]   rsp_valid;
  logic [3:0]   rsp_ready = '0;
  logic [255:0] rsp_data;
  logic         rsp_err;
  logic         busy;
  logic         eng_start;
  logic [127:0] eng_a;
  logic [127:0] eng_b;
  logic [255:0] eng_c = '0;
  logic         eng_done = 1'b0;
  logic         eng_rst_n;

  matrix_add_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .eng_start (eng_start),
    .eng_a     (eng_a),
    .eng_b     (eng_b),
    .eng_c     (eng_c),
    .eng_done  (eng_done),
    .eng_rst_n (eng_rst_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;

  // Engine model: adds element-wise, raises done 3 cycles after start unless hung.
  logic eng_hang = 1'b0;
  logic e_run = 1'b0;
  int   e_lat = 0;
  int   done_cyc = 0;
  always @(posedge clk) begin
    #1;
    if (!eng_rst_n) begin
      eng_done = 1'b0;
      e_run    = 1'b0;
      e_lat    = 0;
    end else if (eng_start && !e_run) begin
      e_run = 1'b1;
      e_lat = 3;
      for (int e = 0; e < 16; e++)
        eng_c[e*16 +: 16] = {8'h00, eng_a[e*8 +: 8]} + {8'h00, eng_b[e*8 +: 8]};
    end else if (e_run && e_lat > 0) begin
      e_lat = e_lat - 1;
      if (e_lat == 0 && !eng_hang) begin
        eng_done = 1'b1;
        done_cyc = cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] amat(input int scale, input int offset);
    logic [127:0] m;
    for (int e = 0; e < 16; e++) m[e*8 +: 8] = 8'(scale * e + offset);
    return m;
  endfunction

  function automatic logic [255:0] cmat(input int scale, input int offset);
    logic [255:0] m;
    for (int e = 0; e < 16; e++) m[e*16 +: 16] = 16'(scale * e + offset);
    return m;
  endfunction

  task automatic set_req(input int r, input logic [127:0] a, input logic [127:0] b);
    req_a[r*128 +: 128] = a;
    req_b[r*128 +: 128] = b;
  endtask

  int rsp_cyc = 0, gnt_cyc = 0, n_start = 0, n_rstlow = 0, last_rstlow = 0, n_rdy = 0;

  task automatic wait_grant(input string tag, input int budget);
    logic got;
    got = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (req_ready != 4'b0) begin
        got = 1'b1;
        gnt_cyc = cyc;
        break;
      end
    end
    check(tag, 256'(got), 256'(1));
  endtask

  task automatic wait_rsp(input string tag, input int budget);
    logic got;
    got = 1'b0;
    n_start = 0; n_rstlow = 0; n_rdy = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (eng_start) n_start++;
      if (!eng_rst_n) begin n_rstlow++; last_rstlow = cyc; end
      if (req_ready != 4'b0) n_rdy++;
      if (rsp_valid != 4'b0) begin
        got = 1'b1;
        rsp_cyc = cyc;
        break;
      end
    end
    check(tag, 256'(got), 256'(1));
  endtask

  int exp_g [5] = '{0, 1, 2, 3, 0};
  int prev_rsp;
  int bad;
  int acc_cyc;
  logic [255:0] held;

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", 256'({req_ready, rsp_valid, eng_start, busy, rsp_err, eng_rst_n}), 256'(0));
    check("rst_eng_a", 256'(eng_a), 256'(0));
    check("rst_data", rsp_data, 256'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    rsp_ready = 4'hF;

    // Single request r0: A=i*4+j, B=10
    set_req(0, amat(1, 0), amat(0, 10));
    @(posedge clk); #1 req_valid = 4'b0001;
    @(negedge clk);
    check("t1_grant", 256'(req_ready), 256'(4'b0001));
    @(posedge clk); #1 req_valid = 4'b0000;
    wait_rsp("t1_rsp_seen", 100);
    check("t1_start_len", 256'(n_start), 256'(2));
    check("t1_ready_once", 256'(n_rdy), 256'(0));
    check("t1_latency", 256'(rsp_cyc - done_cyc), 256'(11));
    check("t1_rsp_valid", 256'(rsp_valid), 256'(4'b0001));
    check("t1_data", rsp_data, cmat(1, 10));
    check("t1_err", 256'(rsp_err), 256'(0));
    check("t1_eng_a_held", 256'(eng_a), 256'(amat(1, 0)));

    // Max operands: 255+255 = 510 in every element
    set_req(0, amat(0, 255), amat(0, 255));
    @(posedge clk); #1 req_valid = 4'b0001;
    wait_grant("t2_grant_seen", 10);
    @(posedge clk); #1 req_valid = 4'b0000;
    wait_rsp("t2_rsp_seen", 100);
    check("t2_data", rsp_data, {16{16'h01FE}});

    // Fresh reset, then all four requesters contend
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int r = 0; r < 4; r++) set_req(r, amat(1, 16 * r), amat(0, r + 1));
    req_valid = 4'hF;
    prev_rsp = 0;
    for (int n = 0; n < 5; n++) begin
      wait_grant("t3_grant_seen", 10);
      check($sformatf("t3_grant%0d", n), 256'(req_ready), 256'(4'b0001 << exp_g[n]));
      if (n > 0) check($sformatf("t3_gap%0d", n), 256'(gnt_cyc - prev_rsp), 256'(1));
      @(posedge clk); #1 if (n == 4) req_valid = 4'b0000;
      wait_rsp("t3_rsp_seen", 100);
      check($sformatf("t3_valid%0d", n), 256'(rsp_valid), 256'(4'b0001 << exp_g[n]));
      check($sformatf("t3_data%0d", n), rsp_data, cmat(1, 17 * exp_g[n] + 1));
      prev_rsp = rsp_cyc;
    end

    // Engine hang on r2: timeout error response
    eng_hang = 1'b1;
    set_req(2, amat(1, 1), amat(1, 1));
    @(posedge clk); #1 req_valid = 4'b0100;
    wait_grant("t4_grant_seen", 10);
    check("t4_grant", 256'(req_ready), 256'(4'b0100));
    @(posedge clk); #1 req_valid = 4'b0000;
    wait_rsp("t4_rsp_seen", 2200);
    check("t4_latency", 256'(rsp_cyc - gnt_cyc), 256'(3 + 2048 + 5));
    check("t4_rstlow", 256'(n_rstlow), 256'(4));
    check("t4_rstlow_end", 256'(rsp_cyc - last_rstlow), 256'(1));
    check("t4_valid", 256'(rsp_valid), 256'(4'b0100));
    check("t4_err", 256'(rsp_err), 256'(1));
    check("t4_data", rsp_data, 256'(0));
    eng_hang = 1'b0;

    // Backpressure on r1 while r2 waits
    rsp_ready = 4'b1101;
    set_req(1, amat(1, 200), amat(0, 100));
    set_req(2, amat(3, 0), amat(0, 7));
    @(posedge clk); #1 req_valid = 4'b0010;
    wait_grant("t5_grant_seen", 10);
    check("t5_grant1", 256'(req_ready), 256'(4'b0010));
    @(posedge clk); #1 req_valid = 4'b0100;
    wait_rsp("t5_rsp_seen", 100);
    check("t5_data1", rsp_data, cmat(1, 300));
    held = rsp_data;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid !== 4'b0010 || rsp_data !== held || req_ready !== 4'b0000) bad++;
    end
    check("t5_stall_stable", 256'(bad), 256'(0));
    @(posedge clk); #1 rsp_ready = 4'hF;
    @(negedge clk);
    acc_cyc = cyc;
    check("t5_valid_at_accept", 256'(rsp_valid), 256'(4'b0010));
    wait_grant("t5_grant2_seen", 5);
    check("t5_grant2", 256'(req_ready), 256'(4'b0100));
    check("t5_grant2_time", 256'(gnt_cyc - acc_cyc), 256'(1));
    @(posedge clk); #1 req_valid = 4'b0000;
    wait_rsp("t5_rsp2_seen", 100);
    check("t5_data2", rsp_data, cmat(3, 7));

    // Reset during WAIT aborts; a later r0 request completes
    eng_hang = 1'b1;
    set_req(0, amat(2, 5), amat(1, 1));
    @(posedge clk); #1 req_valid = 4'b0001;
    wait_grant("t6_grant_seen", 10);
    @(posedge clk); #1 req_valid = 4'b0000;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_ctrl", 256'({req_ready, rsp_valid, eng_start, busy, rsp_err, eng_rst_n}), 256'(0));
    check("t6_rst_eng_a", 256'(eng_a), 256'(0));
    check("t6_rst_data", rsp_data, 256'(0));
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    eng_hang = 1'b0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rsp_valid !== 4'b0000 || busy !== 1'b0) bad++;
    end
    check("t6_no_rsp", 256'(bad), 256'(0));
    @(posedge clk); #1 req_valid = 4'b0001;
    wait_grant("t6_grant2_seen", 10);
    check("t6_grant2", 256'(req_ready), 256'(4'b0001));
    @(posedge clk); #1 req_valid = 4'b0000;
    wait_rsp("t6_rsp_seen", 100);
    check("t6_data", rsp_data, cmat(3, 6));
    check("t6_err", 256'(rsp_err), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/matrix_add_arbiter.md
# matrix_add_arbiter

Round-robin arbiter and sequencer that shares one `matrix_addition` engine (4×4, 8-bit operands, 16-bit results) between `NUM_REQ` requesters. It sits between the NPU command ports and the engine. It latches the granted requester's operands and drives the engine's start pulse. It also collects the result after a settle window, resets the engine between operations and returns the result through a per-requester valid/ready response. A watchdog converts a missing engine `done` into an error response.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `START_CYCLES`, 2: cycles `eng_start` is held high per operation.
- `SETTLE_CYCLES`, 6: cycles waited after engine `done` before capturing `eng_c`.
- `ENG_RST_CYCLES`, 4: cycles `eng_rst_n` is held low after each operation.
- `TIMEOUT_CYCLES`, 2048: maximum cycles in WAIT before declaring timeout.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  NUM_REQ  per-requester request.
- `req_ready`  out  NUM_REQ  one-hot; one-cycle pulse, operands accepted.
- `req_a`  in  NUM_REQ*128  operand A per requester; element [i][j] at bits r*128+(i*4+j)*8 +: 8.
- `req_b`  in  NUM_REQ*128  operand B, same packing.
- `rsp_valid`  out  NUM_REQ  one-hot; result available for that requester.
- `rsp_ready`  in  NUM_REQ  per-requester response accept.
- `rsp_data`  out  256  shared result bus; element [i][j] at bits (i*4+j)*16 +: 16.
- `rsp_err`  out  1  qualifies `rsp_data`; 1 = engine timeout, data is all zero.
- `busy`  out  1  high in every state except IDLE.
- `eng_start`, `eng_a`[128], `eng_b`[128]  out  engine drive; `eng_a`/`eng_b` use the same packing as `req_a`/`req_b`.
- `eng_c`[256], `eng_done`[1]  in  engine result and completion.
- `eng_rst_n`  out  1  engine reset; equals `rst_n` AND NOT (state==CLEAR).

## Operation
- States: IDLE, ISSUE, WAIT, SETTLE, CLEAR, RESP.
- IDLE, with any `req_valid` set:
  - Grant the first set bit searching upward from `last_grant`+1, wrapping modulo NUM_REQ.
  - Pulse `req_ready[g]`.
  - Latch `req_a[g]` and `req_b[g]` into `eng_a` and `eng_b`. These stay stable until the next grant.
  - Store `g` and go to ISSUE.
- ISSUE: `eng_start`=1 for exactly START_CYCLES cycles, then go to WAIT. The timeout counter clears on WAIT entry.
- WAIT:
  - `eng_done` sampled high: go to SETTLE.
  - Counter reaches TIMEOUT_CYCLES first: set `rsp_err`=1, clear the result register to 0, go to CLEAR.
  - `eng_done` high while in ISSUE is ignored.
- SETTLE: count SETTLE_CYCLES cycles. At the last one, capture `eng_c` into the result register, set `rsp_err`=0 and go to CLEAR.
- CLEAR: `eng_rst_n`=0 for ENG_RST_CYCLES cycles, then go to RESP.
- RESP:
  - `rsp_valid[g]`=1; `rsp_data`/`rsp_err` driven from registers.
  - Hold until `rsp_ready[g]`, then drop `rsp_valid`, set `last_grant`=g and go to IDLE.
  - `rsp_ready` of other requesters is ignored.
- No arithmetic is performed in this block; results pass through unchanged at full 16-bit width.
- `req_valid` dropped by a requester after grant has no effect; the operation completes and the response is still presented.

## Timing
- Reset (async assert, sync deassert behaviour via flops):
  - `req_ready`, `rsp_valid`, `eng_start`, `busy`, `rsp_err` = 0.
  - `eng_a`, `eng_b`, `rsp_data` = 0.
  - `eng_rst_n` = 0.
  - state = IDLE; `last_grant` = NUM_REQ-1, so the first grant goes to requester 0.
- Reset mid-operation: abort immediately. No response is issued, and the engine is reset through `eng_rst_n`.
- Grant in cycle T: `req_ready` high in T; `eng_start` high T+1..T+START_CYCLES; WAIT from T+START_CYCLES+1.
- `eng_done` first sampled high in WAIT at cycle D:
  - SETTLE D+1..D+SETTLE_CYCLES; capture at the end of D+SETTLE_CYCLES.
  - CLEAR through D+SETTLE_CYCLES+ENG_RST_CYCLES.
  - `rsp_valid` rises at D+SETTLE_CYCLES+ENG_RST_CYCLES+1 (D+11 by default).
- Timeout: `rsp_valid` rises ENG_RST_CYCLES+1 cycles after the timeout cycle.
- Response accepted in cycle R: IDLE in R+1; the next grant may occur in R+1.
- Minimum request-to-request spacing: 2+START_CYCLES+SETTLE_CYCLES+ENG_RST_CYCLES cycles plus engine latency.
- Simultaneous requests are served one per operation in round-robin order; no requester waits more than NUM_REQ-1 operations.

## Test plan
- Single request, r0, A[i][j]=i*4+j, B all 10, `rsp_ready` tied high:
  - `req_ready[0]` pulses once and `eng_start` is high 2 cycles.
  - `rsp_valid[0]` appears 11 cycles after `done`.
  - C[i][j]=i*4+j+10; `rsp_err`=0.
- Max values, A=B all 255 → every C element = 510 (16'h01FE), no truncation.
- All four requesters held valid with distinct operands → grants in order 0,1,2,3,0; each response carries its own sums on the one-hot `rsp_valid` bit.
- Engine `done` held low → `rsp_valid[g]` with `rsp_err`=1 and `rsp_data`=0 after 2048+5 cycles in WAIT; `eng_rst_n` low 4 cycles beforehand.
- Backpressure, `rsp_ready[1]` low for 20 cycles while r2 requests:
  - `rsp_valid[1]` and `rsp_data` stay stable and r2 gets no grant.
  - r2 is granted the cycle after acceptance.
- `rst_n` asserted during WAIT → all outputs return to reset values immediately and no response is issued; after release, a new r0 request completes normally.
